// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP entry-SRAM arbiter: response-owner encoding and sizing helper.
package rv_iopmp_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CFG  = 2'd1,
    OWN_TL   = 2'd2,
    OWN_NONE = 2'd3
  } arb_owner_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_iopmp_sram_arbiter_if.sv
// Bus bundle for the entry-SRAM arbiter: config port, TL read ports and SRAM port.
// Signal suffixes are taken from the arbiter's point of view (slave modport).
interface rv_iopmp_sram_arbiter_if
  import rv_iopmp_pkg::*;
#(
  parameter int NUM_REQ    = 1,
  parameter int NUM_WORDS  = 8,
  parameter int DATA_WIDTH = 64
);
  localparam int AW = clog2_min1(NUM_WORDS);

  logic                           cfg_req_i;
  logic                           cfg_we_i;
  logic [AW-1:0]                  cfg_addr_i;
  logic [DATA_WIDTH-1:0]          cfg_wdata_i;
  logic [DATA_WIDTH/8-1:0]        cfg_be_i;
  logic                           cfg_gnt_o;
  logic                           cfg_rvalid_o;
  logic [DATA_WIDTH-1:0]          cfg_rdata_o;

  logic [NUM_REQ-1:0]             tl_req_i;
  logic [NUM_REQ-1:0][AW-1:0]     tl_addr_i;
  logic [NUM_REQ-1:0]             tl_gnt_o;
  logic [NUM_REQ-1:0]             tl_rvalid_o;
  logic [DATA_WIDTH-1:0]          tl_rdata_o;

  logic                           sram_req_o;
  logic                           sram_we_o;
  logic [AW-1:0]                  sram_addr_o;
  logic [DATA_WIDTH-1:0]          sram_wdata_o;
  logic [DATA_WIDTH/8-1:0]        sram_be_o;
  logic [DATA_WIDTH-1:0]          sram_rdata_i;

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_be_i,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o,
    input  tl_req_i, tl_addr_i,
    output tl_gnt_o, tl_rvalid_o, tl_rdata_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
    input  sram_rdata_i
  );

  modport master (
    output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_be_i,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o,
    output tl_req_i, tl_addr_i,
    input  tl_gnt_o, tl_rvalid_o, tl_rdata_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
    output sram_rdata_i
  );

endinterface

// File: rtl/rv_iopmp_rr_arbiter.sv
// Round-robin one-hot selector; the pointer moves past the winner only when advance_i is set.
module rv_iopmp_rr_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter  int NUM_REQ = 1,
  localparam int IW      = clog2_min1(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand_s;
  logic          found_s;

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    cand_s  = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found_s && req_i[cand_s]) begin
        found_s       = 1'b1;
        gnt_o[cand_s] = 1'b1;
        idx_o         = cand_s;
      end
    end
  end

  always_comb begin
    if (advance_i) begin
      ptr_d = IW'((int'(idx_o) + 1) % NUM_REQ);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rv_iopmp_sram_arbiter.sv
// Entry-SRAM arbiter: config port vs. NUM_REQ TL readers, starvation-bounded, 1-cycle responses.
// Optional build macro RV_IOPMP_SRAM_ARB_PERF_EN adds the 32-bit contention_cnt_o counter.
module rv_iopmp_sram_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int NUM_REQ        = 1,
  parameter int NUM_WORDS      = 8,
  parameter int DATA_WIDTH     = 64,
  parameter int CFG_STARVE_MAX = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  rv_iopmp_sram_arbiter_if.slave   bus
`ifdef RV_IOPMP_SRAM_ARB_PERF_EN
  ,
  output logic [31:0]              contention_cnt_o
`endif
);

  localparam int AW = clog2_min1(NUM_WORDS);
  localparam int IW = clog2_min1(NUM_REQ);
  localparam int SW = clog2_min1(CFG_STARVE_MAX + 1);
  localparam logic [AW:0]   NUM_WORDS_L  = (AW + 1)'(NUM_WORDS);
  localparam logic [SW-1:0] STARVE_MAX_L = SW'(CFG_STARVE_MAX);

  logic [NUM_REQ-1:0] rr_gnt_s;
  logic [IW-1:0]      rr_idx_s;
  logic               any_tl_s, cfg_win_s, tl_win_s, in_range_s;
  logic [AW-1:0]      win_addr_s;
  logic               own_cfg_s, own_tl_s;

  logic [SW-1:0]      starve_q, starve_d;
  arb_owner_e         owner_q, owner_d;
  logic [IW-1:0]      own_idx_q, own_idx_d;
  logic               own_is_cfg_q, own_is_cfg_d;
  logic               own_we_q, own_we_d;

  rv_iopmp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (bus.tl_req_i),
    .advance_i (tl_win_s),
    .gnt_o     (rr_gnt_s),
    .idx_o     (rr_idx_s)
  );

  // Grant decision; reset forces every grant and SRAM strobe low.
  always_comb begin
    any_tl_s   = |bus.tl_req_i;
    cfg_win_s  = !rst_i && bus.cfg_req_i && !(any_tl_s && (starve_q == STARVE_MAX_L));
    tl_win_s   = !rst_i && any_tl_s && !cfg_win_s;
    win_addr_s = cfg_win_s ? bus.cfg_addr_i : bus.tl_addr_i[rr_idx_s];
    in_range_s = ({1'b0, win_addr_s} < NUM_WORDS_L);

    bus.cfg_gnt_o    = cfg_win_s;
    bus.tl_gnt_o     = tl_win_s ? rr_gnt_s : '0;
    bus.sram_req_o   = (cfg_win_s || tl_win_s) && in_range_s;
    bus.sram_we_o    = bus.sram_req_o && cfg_win_s && bus.cfg_we_i;
    bus.sram_addr_o  = bus.sram_req_o ? win_addr_s : '0;
    bus.sram_wdata_o = bus.sram_we_o ? bus.cfg_wdata_i : '0;
    bus.sram_be_o    = bus.sram_we_o ? bus.cfg_be_i : '0;
  end

  // Next owner and starvation count.
  always_comb begin
    owner_d      = OWN_IDLE;
    own_idx_d    = '0;
    own_is_cfg_d = 1'b0;
    own_we_d     = 1'b0;
    if (cfg_win_s) begin
      owner_d      = in_range_s ? OWN_CFG : OWN_NONE;
      own_is_cfg_d = 1'b1;
      own_we_d     = bus.cfg_we_i;
    end else if (tl_win_s) begin
      owner_d   = in_range_s ? OWN_TL : OWN_NONE;
      own_idx_d = rr_idx_s;
    end else begin
      owner_d = OWN_IDLE;
    end

    if (cfg_win_s && any_tl_s) begin
      starve_d = (starve_q == STARVE_MAX_L) ? starve_q : starve_q + SW'(1);
    end else if (tl_win_s || !any_tl_s) begin
      starve_d = '0;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q     <= '0;
      owner_q      <= OWN_IDLE;
      own_idx_q    <= '0;
      own_is_cfg_q <= 1'b0;
      own_we_q     <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      owner_q      <= owner_d;
      own_idx_q    <= own_idx_d;
      own_is_cfg_q <= own_is_cfg_d;
      own_we_q     <= own_we_d;
    end
  end

  // Response routing; OWN_NONE answers zero to whichever side was granted.
  always_comb begin
    own_cfg_s = (owner_q == OWN_CFG) || ((owner_q == OWN_NONE) && own_is_cfg_q);
    own_tl_s  = (owner_q == OWN_TL)  || ((owner_q == OWN_NONE) && !own_is_cfg_q);

    bus.cfg_rvalid_o = own_cfg_s;
    bus.cfg_rdata_o  = ((owner_q == OWN_CFG) && !own_we_q) ? bus.sram_rdata_i : '0;
    bus.tl_rdata_o   = (owner_q == OWN_TL) ? bus.sram_rdata_i : '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.tl_rvalid_o[i] = own_tl_s && (own_idx_q == IW'(i));
    end
  end

`ifdef RV_IOPMP_SRAM_ARB_PERF_EN
  int          act_cnt_s;
  logic [31:0] contention_q;

  always_comb begin
    act_cnt_s = bus.cfg_req_i ? 1 : 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.tl_req_i[i]) begin
        act_cnt_s = act_cnt_s + 1;
      end else begin
        act_cnt_s = act_cnt_s;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      contention_q <= 32'd0;
    end else if (act_cnt_s > 1) begin
      contention_q <= contention_q + 32'd1;
    end else begin
      contention_q <= contention_q;
    end
  end

  assign contention_cnt_o = contention_q;
`endif

endmodule

// File: doc/rv_iopmp_sram_arbiter.md
RV_IOPMP_SRAM_ARBITER -- requirements
Module: rv_iopmp_sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 1: number of transaction-logic read requesters.
REQ-002 SHALL have parameter NUM_WORDS, default 8: entry SRAM depth; AW = $clog2(NUM_WORDS), minimum 1.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: SRAM word width.
REQ-004 SHALL have parameter CFG_STARVE_MAX, default 4: maximum consecutive config grants while any TL request is pending.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk_i in 1 (rising-edge clock); rst_i in 1 (reset, active-high, asynchronous).
REQ-006 SHALL have the config port: cfg_req_i in 1; cfg_we_i in 1; cfg_addr_i in AW; cfg_wdata_i in DATA_WIDTH; cfg_be_i in DATA_WIDTH/8; cfg_gnt_o out 1; cfg_rvalid_o out 1; cfg_rdata_o out DATA_WIDTH.
REQ-007 SHALL have the TL ports: tl_req_i in NUM_REQ; tl_addr_i in NUM_REQ x AW; tl_gnt_o out NUM_REQ (one-hot); tl_rvalid_o out NUM_REQ (one-hot); tl_rdata_o out DATA_WIDTH (shared).
REQ-008 SHALL have the SRAM ports: sram_req_o out 1; sram_we_o out 1; sram_addr_o out AW; sram_wdata_o out DATA_WIDTH; sram_be_o out DATA_WIDTH/8; sram_rdata_i in DATA_WIDTH (1-cycle read latency).

Function
REQ-009 SHALL grant at most one requester per cycle, combinationally from the current requests.
REQ-010 Requester SHALL hold req and address stable until gnt; the arbiter SHALL NOT depend on requests being withdrawn.
REQ-011 Config SHALL win by default; when starve_cnt == CFG_STARVE_MAX and any tl_req_i is set, a TL requester SHALL win instead.
REQ-012 starve_cnt SHALL increment on each config grant while any tl_req_i is set, clear on any TL grant or when no TL request is pending, and saturate at CFG_STARVE_MAX.
REQ-013 TL winner SHALL be chosen round-robin; the pointer SHALL advance to (winner+1) mod NUM_REQ only on a TL grant.
REQ-014 A granted in-range access SHALL drive sram_req_o=1 in the same cycle with the winner's address; sram_we_o, sram_wdata_o and sram_be_o SHALL follow the config port for config grants, and sram_we_o=0 for TL grants.
REQ-015 A read SHALL assert the owner's rvalid exactly 1 cycle after gnt, with rdata = sram_rdata_i; a config write SHALL also assert cfg_rvalid_o 1 cycle later, with cfg_rdata_o = 0.
REQ-016 A response-owner register SHALL have states IDLE, CFG, TL(idx), NONE. Each cycle it loads the grant result: CFG for a config grant, TL(idx) for a TL grant, NONE for an out-of-range grant, IDLE for no grant.
REQ-017 An address >= NUM_WORDS SHALL be granted with sram_req_o=0, and return rvalid 1 cycle later with rdata = 0.
REQ-018 Back-to-back grants SHALL sustain 1 access per cycle.
REQ-019 A TL read issued in the cycle after a config write to the same address SHALL return the new data.
REQ-020 Every rdata output SHALL be 0 when its rvalid is 0.

Reset
REQ-021 On rst_i, regardless of any transfer in flight: pointer=0, starve_cnt=0, owner=IDLE. All gnt, rvalid and sram_* outputs SHALL be 0; any in-flight response SHALL be dropped.

Configuration
REQ-022 With RV_IOPMP_SRAM_ARB_PERF_EN defined, the block SHALL add output contention_cnt_o (32 bits), which counts cycles with more than one active request, wraps at 2^32, and resets to 0.
REQ-023 Without RV_IOPMP_SRAM_ARB_PERF_EN, the port and the counter SHALL be absent and arbitration SHALL be unchanged.

Structure
REQ-024 The owner-state enum (arb_owner_e) SHALL live in rv_iopmp_pkg.
REQ-025 Round-robin selection SHALL be a sub-module, rv_iopmp_rr_arbiter (NUM_REQ requests in, one-hot grant out, advance input).

Verification
REQ-026 Config read at addr 3 holding 0xDEAD, no TL requests -> cfg_gnt_o same cycle, cfg_rvalid_o=1 and cfg_rdata_o=0xDEAD next cycle.
REQ-027 NUM_REQ=3, all TL requesting continuously, no config -> grants go 0,1,2,0,... with one tl_rvalid_o per cycle.
REQ-028 Config and TL0 both requesting continuously, CFG_STARVE_MAX=4 -> 4 config grants, then 1 TL0 grant, repeating.
REQ-029 Config writes 0x55 to addr 2, then TL1 reads addr 2 in the next cycle -> tl_rdata_o=0x55.
REQ-030 TL read at addr NUM_WORDS -> granted, sram_req_o=0, tl_rvalid_o 1 cycle later with rdata=0.
REQ-031 rst_i asserted in the cycle after a grant -> no rvalid is produced, and all outputs are 0 while reset is held.
